// File: rtl/fadd_pipe.sv
// fadd_pipe: three-stage pipelined IEEE-754 single-precision adder (y = x1 + x2).
// The pipe advances as a whole whenever the output register is empty or being
// drained; otherwise every stage holds. An opaque tag travels with each operation.
module fadd_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    // Leading-zero count over {hidden, mantissa, guard, round, sticky}; 27 when all zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (!found && v[26-i]) begin
                n     = i[4:0];
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic w_adv;

    // ---------------- stage 1: unpack / align ----------------
    logic             w_x1_big;
    logic [31:0]      w_big, w_sml;
    logic [7:0]       w_eb, w_es, w_diff;
    logic [23:0]      w_mb, w_ms;
    logic [4:0]       w_shamt;
    logic [55:0]      w_align;
    logic             w_inf1, w_inf2, w_nan1, w_nan2, w_spec;
    logic [31:0]      w_spec_y;

    logic             r1_valid;
    logic [TAG_W-1:0] r1_tag;
    logic             r1_sign, r1_sub, r1_zsign, r1_sticky, r1_spec;
    logic [7:0]       r1_exp;
    logic [23:0]      r1_mb;
    logic [25:0]      r1_ms;
    logic [31:0]      r1_spec_y;

    // Pick the larger magnitude; a raw {exp,mant} compare orders finite values correctly.
    always_comb begin
        w_x1_big = (x1[30:0] >= x2[30:0]);
        w_big    = w_x1_big ? x1 : x2;
        w_sml    = w_x1_big ? x2 : x1;
        w_eb     = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
        w_es     = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
        w_mb     = {w_big[30:23] != 8'd0, w_big[22:0]};
        w_ms     = {w_sml[30:23] != 8'd0, w_sml[22:0]};
        w_diff   = w_eb - w_es;
        w_shamt  = (w_diff > 8'd31) ? 5'd31 : w_diff[4:0];
        w_align  = {w_ms, 32'd0} >> w_shamt;
    end

    // Infinity / NaN handling; NaNs are always returned quieted.
    always_comb begin
        w_inf1   = (x1[30:23] == 8'hFF);
        w_inf2   = (x2[30:23] == 8'hFF);
        w_nan1   = w_inf1 && (x1[22:0] != 23'd0);
        w_nan2   = w_inf2 && (x2[22:0] != 23'd0);
        w_spec   = w_inf1 | w_inf2;
        w_spec_y = '0;
        if (w_inf1 && !w_inf2)
            w_spec_y = w_nan1 ? (x1 | 32'h0040_0000) : x1;
        else if (!w_inf1 && w_inf2)
            w_spec_y = w_nan2 ? (x2 | 32'h0040_0000) : x2;
        else if (w_inf1 && w_inf2) begin
            if (w_nan2)
                w_spec_y = x2 | 32'h0040_0000;
            else if (w_nan1)
                w_spec_y = x1 | 32'h0040_0000;
            else if (x1[31] == x2[31])
                w_spec_y = x1;
            else
                w_spec_y = 32'hFFC0_0000;
        end
    end

    // Stage-1 register: aligned operands, guard/round kept, shifted-out bits ORed into sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r1_tag    <= '0;
            r1_sign   <= 1'b0;
            r1_sub    <= 1'b0;
            r1_zsign  <= 1'b0;
            r1_sticky <= 1'b0;
            r1_spec   <= 1'b0;
            r1_exp    <= '0;
            r1_mb     <= '0;
            r1_ms     <= '0;
            r1_spec_y <= '0;
        end else if (w_adv) begin
            r1_valid  <= in_valid;
            r1_tag    <= in_tag;
            r1_sign   <= w_big[31];
            r1_sub    <= x1[31] ^ x2[31];
            r1_zsign  <= x1[31] & x2[31];
            r1_sticky <= |w_align[29:0];
            r1_spec   <= w_spec;
            r1_exp    <= w_eb;
            r1_mb     <= w_mb;
            r1_ms     <= w_align[55:30];
            r1_spec_y <= w_spec_y;
        end
    end

    // ---------------- stage 2: add / normalize count ----------------
    // The sticky bit rides as an extra LSB through the subtract so that a borrow
    // from discarded bits is reflected in the integer part, not lost.
    logic [27:0]      w_a, w_b, w_sum, w_norm;
    logic [7:0]       w_exp2, w_lim;
    logic [4:0]       w_lz, w_shift;

    logic             r2_valid;
    logic [TAG_W-1:0] r2_tag;
    logic             r2_sign, r2_zsign, r2_zero, r2_spec;
    logic [7:0]       r2_exp;
    logic [27:0]      r2_w;
    logic [4:0]       r2_shift;
    logic [31:0]      r2_spec_y;

    // Magnitude add/subtract, carry-out renormalize, clamped leading-zero count.
    always_comb begin
        w_a     = {1'b0, r1_mb, 3'b000};
        w_b     = {1'b0, r1_ms, r1_sticky};
        w_sum   = r1_sub ? (w_a - w_b) : (w_a + w_b);
        w_norm  = w_sum[27] ? {1'b0, w_sum[27:2], w_sum[1] | w_sum[0]} : w_sum;
        w_exp2  = r1_exp + {7'd0, w_sum[27]};
        w_lz    = lzc27(w_norm[26:0]);
        w_lim   = w_exp2 - 8'd1;
        w_shift = ({3'd0, w_lz} > w_lim) ? w_lim[4:0] : w_lz;
    end

    // Stage-2 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid  <= 1'b0;
            r2_tag    <= '0;
            r2_sign   <= 1'b0;
            r2_zsign  <= 1'b0;
            r2_zero   <= 1'b0;
            r2_spec   <= 1'b0;
            r2_exp    <= '0;
            r2_w      <= '0;
            r2_shift  <= '0;
            r2_spec_y <= '0;
        end else if (w_adv) begin
            r2_valid  <= r1_valid;
            r2_tag    <= r1_tag;
            r2_sign   <= r1_sign;
            r2_zsign  <= r1_zsign;
            r2_zero   <= (w_norm == 28'd0);
            r2_spec   <= r1_spec;
            r2_exp    <= w_exp2;
            r2_w      <= w_norm;
            r2_shift  <= w_shift;
            r2_spec_y <= r1_spec_y;
        end
    end

    // ---------------- stage 3: round / pack ----------------
    logic [27:0]      w_n;
    logic [7:0]       w_ef;
    logic             w_up;
    logic [31:0]      w_rnd;
    logic [31:0]      w_y;
    logic             w_ovf;

    logic             r3_valid;
    logic [31:0]      r3_y;
    logic             r3_ovf;
    logic [TAG_W-1:0] r3_tag;

    // Round to nearest even; the mantissa carry ripples into the exponent field,
    // which also lifts a subnormal that rounds up to 2^-126 into exponent 1.
    always_comb begin
        w_n   = r2_w << r2_shift;
        w_ef  = w_n[26] ? (r2_exp - {3'd0, r2_shift}) : 8'd0;
        w_up  = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
        w_rnd = {1'b0, w_ef, w_n[25:3]} + {31'd0, w_up};
        w_y   = {r2_sign, w_rnd[30:0]};
        w_ovf = 1'b0;
        if (r2_spec) begin
            w_y = r2_spec_y;
        end else if (r2_zero) begin
            w_y = {r2_zsign, 31'd0};
        end else if (w_rnd[31] || (w_rnd[30:23] == 8'hFF)) begin
            w_y   = {r2_sign, 8'hFF, 23'd0};
            w_ovf = 1'b1;
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_valid <= 1'b0;
            r3_y     <= '0;
            r3_ovf   <= 1'b0;
            r3_tag   <= '0;
        end else if (w_adv) begin
            r3_valid <= r2_valid;
            r3_y     <= w_y;
            r3_ovf   <= w_ovf;
            r3_tag   <= r2_tag;
        end
    end

    assign w_adv     = ~r3_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r3_valid;
    assign y         = r3_y;
    assign ovf       = r3_ovf;
    assign out_tag   = r3_tag;

endmodule
